pwm_motor_drive: RTL and testbench

Downstream consumer of the rover's clock-divider tick. Turns a single-cycle `tick` enable into a fixed-period PWM with a per-period duty command and direction control for one H-bridge channel. Inserts a dead-time interval on every direction reversal so both bridge inputs are never driven together. One instance per wheel motor; duty and direction come from the drive controller.

---
 rtl/pwm_motor_drive.sv | 141 ++++++++++++++
 tb/tb_pwm_motor_drive.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_motor_drive.sv
// pwm_motor_drive: tick-driven PWM for one H-bridge channel with duty command,
// direction control and dead time on every direction reversal.
// Optional feature macro: PWM_RAMP_EN (duty slews by RAMP_STEP per period).
module pwm_motor_drive #(
    parameter int PERIOD     = 100,
    parameter int DEAD_TICKS = 10,
    parameter int RAMP_STEP  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic [7:0] duty_cmd,
    input  logic       dir_cmd,
    output logic       pwm_a,
    output logic       pwm_b,
    output logic       dir_out,
    output logic       period_start,
    output logic       dead
);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    localparam logic [7:0] PERIOD_C  = 8'(PERIOD);
    localparam logic [7:0] PERIOD_M1 = 8'(PERIOD - 1);
    localparam logic [7:0] DEAD_C    = 8'(DEAD_TICKS);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [7:0] duty_act, duty_n;
    logic [7:0] dead_cnt, dead_cnt_n;
    logic [7:0] duty_sat, duty_boundary, duty_restart;
    logic       dir_n, pstart_n, pwm_n;

    // Move cur toward tgt by at most RAMP_STEP, landing exactly on tgt.
    function automatic logic [7:0] ramp(input logic [7:0] cur, input logic [7:0] tgt);
        logic [8:0] step;
        step = 9'(RAMP_STEP);
        if ({1'b0, cur} + step <= {1'b0, tgt})
            return cur + step[7:0];
        else if ({1'b0, tgt} + step <= {1'b0, cur})
            return cur - step[7:0];
        else
            return tgt;
    endfunction

    // Saturate the command and pick the duty loaded at a boundary or restart.
    always_comb begin
        duty_sat = (duty_cmd > PERIOD_C) ? PERIOD_C : duty_cmd;
`ifdef PWM_RAMP_EN
        duty_boundary = ramp(duty_act, duty_sat);
        duty_restart  = ramp(8'd0, duty_sat);
`else
        duty_boundary = duty_sat;
        duty_restart  = duty_sat;
`endif
    end

    // Next-state and next-output logic; enable outranks tick.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        duty_n     = duty_act;
        dead_cnt_n = dead_cnt;
        dir_n      = dir_out;
        pstart_n   = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            cnt_n   = 8'd0;
            duty_n  = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    // outputs are already low, so direction loads without dead time
                    state_n  = RUN;
                    cnt_n    = 8'd0;
                    duty_n   = duty_restart;
                    dir_n    = dir_cmd;
                    pstart_n = 1'b1;
                end
                RUN: begin
                    if (tick) begin
                        if (cnt == PERIOD_M1) begin
                            cnt_n = 8'd0;
                            if (dir_cmd != dir_out) begin
                                state_n    = DEAD;
                                duty_n     = 8'd0;
                                dead_cnt_n = DEAD_C;
                            end else begin
                                duty_n   = duty_boundary;
                                pstart_n = 1'b1;
                            end
                        end else begin
                            cnt_n = cnt + 8'd1;
                        end
                    end
                end
                DEAD: begin
                    if (tick) begin
                        dead_cnt_n = dead_cnt - 8'd1;
                        if (dead_cnt == 8'd1) begin
                            state_n  = RUN;
                            dir_n    = dir_cmd;
                            cnt_n    = 8'd0;
                            duty_n   = duty_restart;
                            pstart_n = 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        pwm_n = (state_n == RUN) && (cnt_n < duty_n);
    end

    // State and registered outputs, all taken from next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            duty_act     <= 8'd0;
            dead_cnt     <= 8'd0;
            dir_out      <= 1'b0;
            pwm_a        <= 1'b0;
            pwm_b        <= 1'b0;
            period_start <= 1'b0;
            dead         <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            duty_act     <= duty_n;
            dead_cnt     <= dead_cnt_n;
            dir_out      <= dir_n;
            pwm_a        <= pwm_n & dir_n;
            pwm_b        <= pwm_n & ~dir_n;
            period_start <= pstart_n;
            dead         <= (state_n == DEAD);
        end
    end

endmodule

// File: tb/tb_pwm_motor_drive.sv
// Testbench for pwm_motor_drive: per-period high-tick measurement against a
// duty model, reversal dead time, enable drop during DEAD, random duties.
module tb_pwm_motor_drive;

    localparam int PERIOD     = 100;
    localparam int DEAD_TICKS = 10;
    localparam int RAMP_STEP  = 1;
    localparam int PER_BOUND  = 700;

    logic       clk = 1'b0;
    logic       reset, tick, enable, dir_cmd;
    logic [7:0] duty_cmd;
    logic       pwm_a, pwm_b, dir_out, period_start, dead;

    int checks = 0;
    int fails  = 0;

    pwm_motor_drive #(.PERIOD(PERIOD), .DEAD_TICKS(DEAD_TICKS), .RAMP_STEP(RAMP_STEP)) dut (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable),
        .duty_cmd(duty_cmd), .dir_cmd(dir_cmd),
        .pwm_a(pwm_a), .pwm_b(pwm_b), .dir_out(dir_out),
        .period_start(period_start), .dead(dead)
    );

    always #5 clk = ~clk;

    // tick generator: fixed gap or random gap
    int tick_gap = 4;
    bit rand_gap = 0;
    initial begin
        int gcnt;
        gcnt = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gcnt == 0) begin
                tick = 1'b1;
                gcnt = rand_gap ? int'($urandom_range(0, 4)) : tick_gap - 1;
            end else begin
                tick = 1'b0;
                gcnt--;
            end
        end
    end

    // duty command as seen by the DUT at each edge
    logic [7:0] duty_q = 8'd0;
    always @(posedge clk) duty_q <= duty_cmd;

    // reference duty for a new period given the previous applied duty
    function automatic int model_duty(input int base, input int cmd);
        int tgt;
        tgt = (cmd > PERIOD) ? PERIOD : cmd;
`ifdef PWM_RAMP_EN
        if (tgt > base) return (base + RAMP_STEP < tgt) ? base + RAMP_STEP : tgt;
        else            return (base - RAMP_STEP > tgt) ? base - RAMP_STEP : tgt;
`else
        return tgt;
`endif
    endfunction

    // per-period statistics, split at each period_start pulse
    int cur_hi_a, cur_hi_b, cur_ticks, cur_clks, cur_low_a, cur_exp;
    int last_hi_a, last_hi_b, last_ticks, last_clks, last_low_a, last_exp;
    int periods_done = 0, dead_ticks = 0, overlap_err = 0, dead_drive_err = 0;
    bit from_zero = 1, prev_dead = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                cur_hi_a = 0; cur_hi_b = 0; cur_ticks = 0; cur_clks = 0;
                cur_low_a = 0; cur_exp = 0; from_zero = 1; prev_dead = 0;
            end else begin
                if (pwm_a && pwm_b) overlap_err++;
                if (dead && (pwm_a || pwm_b)) dead_drive_err++;
                if (dead && !prev_dead) dead_ticks = 0;
                if (period_start) begin
                    last_hi_a = cur_hi_a; last_hi_b = cur_hi_b; last_ticks = cur_ticks;
                    last_clks = cur_clks; last_low_a = cur_low_a; last_exp = cur_exp;
                    cur_exp = model_duty(from_zero ? 0 : cur_exp, int'(duty_q));
                    from_zero = 0;
                    cur_hi_a = 0; cur_hi_b = 0; cur_ticks = 0; cur_clks = 0; cur_low_a = 0;
                    periods_done++;
                end
                cur_clks++;
                if (!pwm_a) cur_low_a++;
                if (tick) begin
                    cur_ticks++;
                    if (pwm_a) cur_hi_a++;
                    if (pwm_b) cur_hi_b++;
                    if (dead) dead_ticks++;
                end
                if (dead || !enable) from_zero = 1;
                prev_dead = dead;
            end
        end
    end

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_periods(input int n);
        int target, t;
        target = periods_done + n;
        t = 0;
        while (periods_done < target && t < PER_BOUND * n) begin
            nclk();
            t++;
        end
        checks++;
        if (periods_done < target) begin
            fails++;
            $display("FAIL period_wait: got %0d periods, need %0d", periods_done, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; dir_cmd = 1'b0; duty_cmd = 8'd0;
        repeat (3) nclk();
        checks += 5;
        if (pwm_a !== 1'b0)        begin fails++; $display("FAIL reset_pwm_a: got %b need 0", pwm_a); end
        if (pwm_b !== 1'b0)        begin fails++; $display("FAIL reset_pwm_b: got %b need 0", pwm_b); end
        if (dir_out !== 1'b0)      begin fails++; $display("FAIL reset_dir: got %b need 0", dir_out); end
        if (period_start !== 1'b0) begin fails++; $display("FAIL reset_pstart: got %b need 0", period_start); end
        if (dead !== 1'b0)         begin fails++; $display("FAIL reset_dead: got %b need 0", dead); end
        // reset outranks enable
        enable = 1'b1; dir_cmd = 1'b1;
        nclk();
        checks++;
        if (period_start !== 1'b0 || dir_out !== 1'b0) begin
            fails++; $display("FAIL reset_priority: pstart=%b dir=%b need 0 0", period_start, dir_out);
        end
        enable = 1'b0;
        nclk();
        reset = 1'b0;
        nclk();
    endtask

    task automatic test_basic();
        tick_gap = 4; rand_gap = 0;
        dir_cmd = 1'b1; duty_cmd = 8'd30; enable = 1'b1;
        nclk();
        checks += 2;
        if (period_start !== 1'b1) begin fails++; $display("FAIL start_pulse: got %b need 1", period_start); end
        if (dir_out !== 1'b1)      begin fails++; $display("FAIL start_dir: got %b need 1", dir_out); end
        wait_periods(2);
        checks += 4;
        if (last_hi_a !== last_exp) begin fails++; $display("FAIL basic_hi_a: got %0d need %0d", last_hi_a, last_exp); end
        if (last_hi_b !== 0)        begin fails++; $display("FAIL basic_hi_b: got %0d need 0", last_hi_b); end
        if (last_ticks !== PERIOD)  begin fails++; $display("FAIL basic_ticks: got %0d need %0d", last_ticks, PERIOD); end
        if (last_clks !== 4*PERIOD) begin fails++; $display("FAIL basic_period_clks: got %0d need %0d", last_clks, 4*PERIOD); end
    endtask

    task automatic test_mid_change();
        repeat (100) nclk();
        duty_cmd = 8'd60;
        wait_periods(1);
        checks++;
        if (last_hi_a !== last_exp) begin fails++; $display("FAIL midchg_keep: got %0d need %0d", last_hi_a, last_exp); end
        wait_periods(1);
        checks++;
        if (last_hi_a !== last_exp) begin fails++; $display("FAIL midchg_new: got %0d need %0d", last_hi_a, last_exp); end
    endtask

    task automatic test_saturation();
        repeat (40) nclk();
        duty_cmd = 8'd0;
        wait_periods(2);
        checks++;
        if (last_hi_a !== last_exp) begin fails++; $display("FAIL duty_zero: got %0d need %0d", last_hi_a, last_exp); end
        repeat (40) nclk();
        duty_cmd = 8'd200;
        wait_periods(2);
        checks += 2;
        if (last_hi_a !== last_exp) begin fails++; $display("FAIL duty_sat: got %0d need %0d", last_hi_a, last_exp); end
`ifndef PWM_RAMP_EN
        if (last_low_a !== 0) begin fails++; $display("FAIL sat_no_dip: got %0d low clks need 0", last_low_a); end
`else
        if (last_low_a < 0) begin fails++; $display("FAIL sat_low_count: got %0d", last_low_a); end
`endif
    endtask

    task automatic test_random();
        rand_gap = 1;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(1, 60)) nclk();
            duty_cmd = 8'($urandom_range(0, 255));
            wait_periods(1);
            checks += 2;
            if (last_hi_a !== last_exp) begin fails++; $display("FAIL rand_hi[%0d]: got %0d need %0d", i, last_hi_a, last_exp); end
            if (last_ticks !== PERIOD)  begin fails++; $display("FAIL rand_ticks[%0d]: got %0d need %0d", i, last_ticks, PERIOD); end
        end
        rand_gap = 0;
    endtask

    task automatic test_reversal();
        int t;
        duty_cmd = 8'd40;
        wait_periods(2);
        repeat (50) nclk();
        dir_cmd = 1'b0;
        t = 0;
        while (!dead && t < PER_BOUND) begin nclk(); t++; end
        checks += 2;
        if (dead !== 1'b1) begin fails++; $display("FAIL rev_dead_enter: got %b need 1", dead); end
        if (pwm_a !== 1'b0 || pwm_b !== 1'b0) begin fails++; $display("FAIL rev_dead_low: a=%b b=%b need 0 0", pwm_a, pwm_b); end
        t = 0;
        while (dead && t < PER_BOUND) begin nclk(); t++; end
        checks += 3;
        if (dead_ticks !== DEAD_TICKS) begin fails++; $display("FAIL rev_dead_ticks: got %0d need %0d", dead_ticks, DEAD_TICKS); end
        if (dir_out !== 1'b0)          begin fails++; $display("FAIL rev_dir: got %b need 0", dir_out); end
        if (period_start !== 1'b1)     begin fails++; $display("FAIL rev_pstart: got %b need 1", period_start); end
        wait_periods(1);
        checks += 2;
        if (last_hi_b !== last_exp) begin fails++; $display("FAIL rev_hi_b: got %0d need %0d", last_hi_b, last_exp); end
        if (last_hi_a !== 0)        begin fails++; $display("FAIL rev_hi_a: got %0d need 0", last_hi_a); end
    endtask

    task automatic test_enable_drop_dead();
        int t;
        repeat (30) nclk();
        dir_cmd = 1'b1;
        t = 0;
        while (!dead && t < PER_BOUND) begin nclk(); t++; end
        checks++;
        if (dead !== 1'b1) begin fails++; $display("FAIL drop_dead_enter: got %b need 1", dead); end
        repeat (12) nclk();
        enable = 1'b0;
        nclk();
        checks += 2;
        if (pwm_a !== 1'b0 || pwm_b !== 1'b0) begin fails++; $display("FAIL drop_low: a=%b b=%b need 0 0", pwm_a, pwm_b); end
        if (dead !== 1'b0) begin fails++; $display("FAIL drop_dead_clear: got %b need 0", dead); end
        repeat (5) nclk();
        dir_cmd = 1'b0; enable = 1'b1;
        nclk();
        checks += 3;
        if (dir_out !== 1'b0)      begin fails++; $display("FAIL reen_dir: got %b need 0", dir_out); end
        if (period_start !== 1'b1) begin fails++; $display("FAIL reen_pstart: got %b need 1", period_start); end
        if (dead !== 1'b0)         begin fails++; $display("FAIL reen_dead: got %b need 0", dead); end
        wait_periods(1);
        checks += 2;
        if (last_hi_b !== last_exp) begin fails++; $display("FAIL reen_hi_b: got %0d need %0d", last_hi_b, last_exp); end
        if (last_ticks !== PERIOD)  begin fails++; $display("FAIL reen_ticks: got %0d need %0d", last_ticks, PERIOD); end
    endtask

    task automatic test_no_overlap();
        checks += 2;
        if (overlap_err !== 0)    begin fails++; $display("FAIL overlap: got %0d cycles need 0", overlap_err); end
        if (dead_drive_err !== 0) begin fails++; $display("FAIL dead_drive: got %0d cycles need 0", dead_drive_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_change();
        test_saturation();
        test_random();
        test_reversal();
        test_enable_drop_dead();
        test_no_overlap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
